// File: rtl/adc_spi_responder_if.sv
// Sample stream and chip-bus signals of the ADC SPI responder.
// The responder connects through the slave modport; the side that feeds samples
// and drives the chip bus (controller or bench) uses the master modport.
interface adc_spi_responder_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid_in;
    logic                  sample_ready_out;
    logic                  chip_sel_in;
    logic                  chip_clk_in;
    logic                  chip_data_out;
    logic                  frame_done_out;
    logic                  frame_abort_out;
    logic                  underrun_out;

    modport slave (
        input  sample_in,
        input  sample_valid_in,
        input  chip_sel_in,
        input  chip_clk_in,
        output sample_ready_out,
        output chip_data_out,
        output frame_done_out,
        output frame_abort_out,
        output underrun_out
    );

    modport master (
        output sample_in,
        output sample_valid_in,
        output chip_sel_in,
        output chip_clk_in,
        input  sample_ready_out,
        input  chip_data_out,
        input  frame_done_out,
        input  frame_abort_out,
        input  underrun_out
    );
endinterface

// File: rtl/adc_spi_responder.sv
// ADC channel emulator on the chip bus: one DATA_WIDTH-bit word per chip-select
// frame, shifted out MSB-first. Words come from a one-entry holding register fed
// by a valid/ready stream; an empty holding register at frame start sends
// UNDERRUN_WORD instead. The bus is generated on the same clock, so cs/dclk are
// registered once purely for edge detection.
module adc_spi_responder #(
    parameter int                    DATA_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = '0
) (
    input logic               clk_in,
    input logic               rst_in,
    adc_spi_responder_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                state_q;
    logic                  cs_q;
    logic                  clk_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_valid_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  data_q;
    logic                  done_q;
    logic                  abort_q;
    logic                  underrun_q;

    logic cs_fall;
    logic cs_rise;
    logic clk_fall;
    logic clk_rise;
    logic accept;
    logic load_hold;

    assign cs_fall  = cs_q & ~bus.chip_sel_in;
    assign cs_rise  = ~cs_q & bus.chip_sel_in;
    assign clk_fall = clk_q & ~bus.chip_clk_in;
    assign clk_rise = ~clk_q & bus.chip_clk_in;

    // Ready depends only on registered state, never on sample_valid_in.
    assign bus.sample_ready_out = ~hold_valid_q;
    assign accept               = bus.sample_valid_in & ~hold_valid_q;
    // The holding register is drained only by a frame start that finds it full;
    // a word accepted in that same cycle waits for the following frame.
    assign load_hold            = (state_q == ST_IDLE) & cs_fall & hold_valid_q;

    assign bus.chip_data_out   = data_q;
    assign bus.frame_done_out  = done_q;
    assign bus.frame_abort_out = abort_q;
    assign bus.underrun_out    = underrun_q;

    // Previous-cycle copies of cs and dclk for edge detection.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cs_q  <= 1'b1;
            clk_q <= 1'b0;
        end else begin
            cs_q  <= bus.chip_sel_in;
            clk_q <= bus.chip_clk_in;
        end
    end

    // One-entry holding register between the sample stream and the shifter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (accept) begin
            hold_q       <= bus.sample_in;
            hold_valid_q <= 1'b1;
        end else if (load_hold) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Frame FSM: shifter, bit counter, registered cipo and status pulses.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            data_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    data_q <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_SHIFT;
                        if (hold_valid_q) begin
                            shreg_q <= hold_q;
                            data_q  <= hold_q[DATA_WIDTH-1];
                        end else begin
                            shreg_q    <= UNDERRUN_WORD;
                            data_q     <= UNDERRUN_WORD[DATA_WIDTH-1];
                            underrun_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        // Aborted word is dropped, not re-sent.
                        abort_q <= 1'b1;
                        shreg_q <= '0;
                        data_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (clk_rise) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            done_q  <= 1'b1;
                            data_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end else if (clk_fall) begin
                        // New bit appears the cycle after the falling edge, well
                        // ahead of the controller's next rising-edge sample.
                        shreg_q <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        data_q  <= shreg_q[DATA_WIDTH-2];
                    end
                end
                ST_DONE: begin
                    data_q <= 1'b0;
                    if (cs_rise) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    data_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: drives spi_con-style frames (dclk period 5 cycles)
// and compares read words and status pulses with a frame-level model built on a
// queue of words the responder has accepted.
module tb_adc_spi_responder;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adc_spi_responder_if #(.DATA_WIDTH(DW)) bus ();

    adc_spi_responder #(
        .DATA_WIDTH   (DW),
        .UNDERRUN_WORD(16'h0000)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [DW-1:0] src[$];   // words offered on the stream, oldest first
    logic [DW-1:0] mq[$];    // words the responder holds (at most one)
    bit            cs_prev = 1'b1;
    logic [DW-1:0] exp_word;
    bit            exp_under;
    int            done_cnt;
    int            abort_cnt;
    int            under_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        bus.sample_valid_in = (src.size() > 0);
        bus.sample_in       = (src.size() > 0) ? src[0] : DW'($urandom);
    endtask

    // One clock: update the model from the inputs presented before the edge,
    // then sample outputs 1 time unit after it.
    task automatic tick();
        bit acc;
        bit csf;
        acc = bus.sample_valid_in && (mq.size() == 0);
        csf = cs_prev && !bus.chip_sel_in;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            cs_prev = 1'b1;
        end else begin
            if (csf) begin
                if (mq.size() > 0) begin
                    exp_word  = mq.pop_front();
                    exp_under = 1'b0;
                end else begin
                    exp_word  = '0;
                    exp_under = 1'b1;
                end
            end
            if (acc) mq.push_back(src.pop_front());
            cs_prev = bus.chip_sel_in;
        end
        #1;
        done_cnt  += int'(bus.frame_done_out);
        abort_cnt += int'(bus.frame_abort_out);
        under_cnt += int'(bus.underrun_out);
        chk("ready", bus.sample_ready_out, (mq.size() == 0));
        drive_src();
    endtask

    // Controller-side frame: cs low, nbits of dclk (2 high / 3 low), reading
    // cipo at each rising edge. With rst_mid the frame is left open.
    task automatic frame(input int nbits, input bit inject, input logic [DW-1:0] inj,
                         input bit rst_mid, output logic [DW-1:0] rd);
        rd        = '0;
        done_cnt  = 0;
        abort_cnt = 0;
        under_cnt = 0;
        if (inject) begin
            src.push_back(inj);
            drive_src();
        end
        bus.chip_sel_in = 1'b0;
        tick();
        tick();
        for (int i = 0; i < nbits; i++) begin
            bus.chip_clk_in = 1'b1;
            rd = {rd[DW-2:0], bus.chip_data_out};
            tick();
            tick();
            bus.chip_clk_in = 1'b0;
            tick();
            tick();
            tick();
        end
        if (!rst_mid) begin
            bus.chip_sel_in = 1'b1;
            tick();
            tick();
        end
    endtask

    task automatic run_frame(input int nbits, input bit inject, input logic [DW-1:0] inj);
        logic [DW-1:0] rd;
        logic [DW-1:0] want;
        bit            full;
        full = (nbits == DW);
        frame(nbits, inject, inj, 1'b0, rd);
        want = exp_word >> (DW - nbits);
        $display("frame nbits=%0d read=%h expect=%h done=%0d abort=%0d underrun=%0d",
                 nbits, rd, want, done_cnt, abort_cnt, under_cnt);
        chk(full ? "word" : "word_partial", rd, want);
        chk("done_pulses", done_cnt, full ? 1 : 0);
        chk("abort_pulses", abort_cnt, full ? 0 : 1);
        chk("underrun_pulses", under_cnt, exp_under ? 1 : 0);
        chk("cipo_idle", bus.chip_data_out, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            nb;

        // Reset state
        rst                 = 1'b1;
        bus.chip_sel_in     = 1'b1;
        bus.chip_clk_in     = 1'b0;
        bus.sample_valid_in = 1'b0;
        bus.sample_in       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.sample_ready_out, 1'b1);
        chk("rst_cipo", bus.chip_data_out, 1'b0);
        chk("rst_done", bus.frame_done_out, 1'b0);
        chk("rst_abort", bus.frame_abort_out, 1'b0);
        chk("rst_underrun", bus.underrun_out, 1'b0);
        rst = 1'b0;
        tick();

        // 1: single loaded word
        src.push_back(16'hA5C3);
        drive_src();
        tick();
        tick();
        chk("ready_full", bus.sample_ready_out, 1'b0);
        run_frame(DW, 1'b0, '0);
        chk("t1_word", exp_word, 16'hA5C3);

        // 2: empty holding register
        run_frame(DW, 1'b0, '0);
        chk("t2_underrun", exp_under, 1'b1);

        // 3: back-to-back stream with valid held high
        src.push_back(16'h0001);
        src.push_back(16'h8000);
        src.push_back(16'hFFFF);
        drive_src();
        tick();
        run_frame(DW, 1'b0, '0);
        run_frame(DW, 1'b0, '0);
        run_frame(DW, 1'b0, '0);
        chk("t3_last_word", exp_word, 16'hFFFF);

        // 4: abort after 7 rising edges, next frame sends next word
        src.push_back(16'h1234);
        src.push_back(16'h5678);
        drive_src();
        tick();
        run_frame(7, 1'b0, '0);
        run_frame(DW, 1'b0, '0);
        chk("t4_next_word", exp_word, 16'h5678);

        // 5: word offered in the cs_fall cycle with hold empty
        run_frame(DW, 1'b1, 16'h00FF);
        chk("t5_underrun", exp_under, 1'b1);
        run_frame(DW, 1'b0, '0);
        chk("t5_next_word", exp_word, 16'h00FF);

        // 6: asynchronous reset mid-frame
        src.push_back(16'h1357);
        drive_src();
        tick();
        frame(5, 1'b0, '0, 1'b1, rd);
        chk("t6_partial", rd, 16'h1357 >> 11);
        rst = 1'b1;
        #1;
        chk("t6_cipo", bus.chip_data_out, 1'b0);
        chk("t6_ready", bus.sample_ready_out, 1'b1);
        bus.chip_sel_in = 1'b1;
        bus.chip_clk_in = 1'b0;
        src.delete();
        mq.delete();
        drive_src();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_abort", abort_cnt, 0);
        chk("t6_no_done", done_cnt, 0);
        src.push_back(16'hBEEF);
        drive_src();
        tick();
        run_frame(DW, 1'b0, '0);
        chk("t6_word", exp_word, 16'hBEEF);

        // Randomised frames: random feeding, lengths and aborts
        for (int it = 0; it < 25; it++) begin
            bit inj;
            inj = (src.size() == 0) && (mq.size() == 0) && ($urandom_range(0, 3) == 0);
            if (!inj) begin
                int k;
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) begin
                    if (src.size() < 2) src.push_back(DW'($urandom));
                end
            end
            drive_src();
            repeat ($urandom_range(0, 3)) tick();
            nb = ($urandom_range(0, 2) != 0) ? DW : $urandom_range(1, DW - 1);
            run_frame(nb, inj, DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
